apb_slave_regs: RTL
===================

# apb_slave_regs

APB (AMBA 3) completer that terminates the `psel`/`penable`/`paddr`/`pwdata`/`pwrite` bus and returns `prdata`/`pready`/`pslverr`. It is the responder end of the APB interface that the APB UVC drives as requester. It holds a small memory-mapped register bank and inserts a programmable number of wait states. It sits directly under the testbench top as the APB DUT.

## Interface
- `NUM_REGS`, default 8: number of 32-bit word registers; must be in 2..16.
- `ID_VALUE`, default 32'hA9B0_0001: reset and constant value of register 0.
- `clk` in 1: bus clock; all state changes on the rising edge.
- `preset` in 1: asynchronous, active-high reset.
- `psel` in 1: completer select.
- `penable` in 1: access-phase indicator.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in 32: byte address.
- `pwdata` in 32: write data.
- `prdata` out 32: read data; valid only while `pready`=1.
- `pready` out 1: transfer-complete indicator.
- `pslverr` out 1: error response; valid only while `pready`=1.

## Operation
- Register map, word index `paddr[5:2]`:
  - 0 = ID: read-only, always `ID_VALUE`.
  - 1 = WAITCFG: R/W; only bits [3:0] are stored, upper bits read as 0. Sets wait states W = 0..15. Reset value is 0.
  - 2..`NUM_REGS`-1 = SCRATCH: full 32-bit R/W. Reset value is 0.
- Error conditions, evaluated at setup:
  - `paddr[1:0]`≠0
  - `paddr[31:6]`≠0
  - index ≥ `NUM_REGS`
  - a write to index 0
- On error: no register is modified, `prdata`=0 and `pslverr`=1 in the completing cycle.
- FSM states are IDLE, WAIT and ACCESS.
  - IDLE: when `psel`=1 and `penable`=0 (setup cycle), capture addr, pwrite, pwdata and the error flag, and load the wait counter with the current W.
    - If W=0, go to ACCESS.
    - Otherwise go to WAIT.
  - WAIT: the counter decrements each cycle while `psel` and `penable` are both 1. When the counter reaches 1, go to ACCESS.
  - ACCESS: `pready`=1 for exactly one cycle.
    - A write commits at the clock edge that ends this cycle.
    - Next state is IDLE. If `psel`=1 and `penable`=0 in the next cycle, that cycle is treated as a new setup, so back-to-back transfers have no idle gap.
- A W change written to WAITCFG takes effect from the next transfer's setup; it never affects the transfer in flight.
- `psel`=0 while in WAIT or ACCESS aborts the transfer: return to IDLE with no write and no response.
- `penable`=1 while in IDLE with no preceding setup is ignored; the block stays in IDLE.
- `pwdata`, `paddr` and `pwrite` changes after the setup cycle are ignored, because they were captured at setup.

## Timing
- Reset values: `pready`=0, `pslverr`=0, `prdata`=0, FSM=IDLE, WAITCFG=0, SCRATCH=0.
- Reset applied mid-transfer clears all state immediately. No partial write ever occurs.
- Outputs are registered, with no combinational path from inputs to outputs.
- Transfer length is 2+W cycles:
  - 1 setup cycle;
  - W access cycles with `pready`=0;
  - 1 access cycle with `pready`=1.
- `prdata` and `pslverr` are nonzero only in the `pready`=1 cycle and are 0 in every other cycle.
- Read data reflects register contents as of the setup-cycle edge.

## Structure
- Shared package `apb_slave_pkg` holds:
  - the FSM state enum (IDLE, WAIT, ACCESS);
  - register index constants (ID=0, WAITCFG=1, first SCRATCH=2);
  - WAITCFG field width (4).
- Natural sub-module: `apb_slave_regbank`, containing the register array, the write port and the read mux. The FSM and wait counter remain in the top module.

## Test plan
- Reset then read 0x00 → `pready` is high on the 2nd cycle, `prdata`=32'hA9B0_0001, `pslverr`=0.
- Write 0x08 = 32'hDEAD_BEEF, then read 0x08 → `prdata`=32'hDEAD_BEEF. Each transfer takes 2 cycles.
- Write 0x04 = 32'hFFFF_FFF3, then read 0x04 → returns 32'h3. The following read of 0x08 shows `pready` low for exactly 3 access cycles, high on the 5th cycle.
- Write 0x00, write 0x0A (unaligned), and read 0x40 → `pslverr`=1 on the `pready` cycle each time, `prdata`=0, and the ID and SCRATCH registers are unchanged.
- Set W=2, start a write to 0x0C, drop `psel` in the 1st wait cycle → no `pready`, and 0x0C still reads 0.
- Set W=2, assert `preset` in the 2nd wait cycle of a write → all outputs are 0 at once, and after release 0x04 and 0x0C read 0.

Source files
------------

// File: rtl/apb_slave_regs_pkg.sv
// Shared FSM state type, register map indices and field widths
// for the APB register-bank completer.
package apb_slave_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS
   } apb_state_e;

   localparam int unsigned REG_IDX_W = 4;
   localparam int unsigned WAITCFG_W = 4;

   localparam logic [REG_IDX_W-1:0] REG_ID       = 4'd0;
   localparam logic [REG_IDX_W-1:0] REG_WAITCFG  = 4'd1;
   localparam logic [REG_IDX_W-1:0] REG_SCRATCH0 = 4'd2;

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB (AMBA 3) bus bundle between a requester (master) and this completer (slave).
interface apb_slave_regs_if;

   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/apb_slave_regbank.sv
// Register array for the APB completer: ID constant, WAITCFG field and
// scratch words, with one write port and one combinational read mux.
module apb_slave_regbank
   import apb_slave_pkg::*;
#(
   parameter int unsigned NUM_REGS = 8,
   parameter logic [31:0] ID_VALUE = 32'hA9B0_0001
) (
   input  logic                 clk,
   input  logic                 preset,
   input  logic                 we,
   input  logic [REG_IDX_W-1:0] widx,
   input  logic [31:0]          wdata,
   input  logic [REG_IDX_W-1:0] ridx,
   output logic [31:0]          rdata,
   output logic [WAITCFG_W-1:0] wait_cfg
);

   localparam int unsigned DEPTH = 2**REG_IDX_W;

   // Spans the whole index space so the 4-bit index selects directly;
   // slots outside the scratch range are never written and stay zero.
   logic [31:0] scratch [DEPTH];

   logic widx_scratch;
   logic ridx_scratch;

   always_comb begin
      widx_scratch = (widx >= REG_SCRATCH0) && (32'(widx) < NUM_REGS);
      ridx_scratch = (ridx >= REG_SCRATCH0) && (32'(ridx) < NUM_REGS);
   end

   always_ff @(posedge clk or posedge preset) begin
      if (preset) begin
         wait_cfg <= '0;
         scratch  <= '{default: '0};
      end else if (we) begin
         if (widx == REG_WAITCFG) begin
            wait_cfg <= wdata[WAITCFG_W-1:0];
         end else if (widx_scratch) begin
            scratch[widx] <= wdata;
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (ridx == REG_ID) begin
         rdata = ID_VALUE;
      end else if (ridx == REG_WAITCFG) begin
         rdata = {{(32-WAITCFG_W){1'b0}}, wait_cfg};
      end else if (ridx_scratch) begin
         rdata = scratch[ridx];
      end
   end

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer: setup capture, programmable wait states and registered
// response over a small memory-mapped register bank.
module apb_slave_regs
   import apb_slave_pkg::*;
#(
   parameter int unsigned NUM_REGS = 8,
   parameter logic [31:0] ID_VALUE = 32'hA9B0_0001
) (
   input logic             clk,
   input logic             preset,
   apb_slave_regs_if.slave apb
);

   apb_state_e           state;
   logic [REG_IDX_W-1:0] idx_q;
   logic                 write_q;
   logic                 err_q;
   logic [31:0]          wdata_q;
   logic [WAITCFG_W-1:0] cnt;

   logic [WAITCFG_W-1:0] wait_cfg;
   logic [31:0]          rdata;
   logic [31:0]          prdata_q;
   logic                 pready_q;
   logic                 pslverr_q;

   logic                 setup;
   logic                 bad_d;
   logic                 go_access;
   logic                 commit;
   logic                 sel_err;
   logic                 sel_wr;
   logic [REG_IDX_W-1:0] idx_d;
   logic [REG_IDX_W-1:0] sel_idx;

   always_comb begin
      idx_d = apb.paddr[5:2];
      setup = apb.psel && !apb.penable;
      bad_d = (apb.paddr[1:0] != '0) || (apb.paddr[31:6] != '0) ||
              (32'(idx_d) >= NUM_REGS) || (apb.pwrite && (idx_d == REG_ID));

      // A zero-wait transfer responds straight out of IDLE, so its response
      // is formed from the live setup-cycle inputs instead of the captures.
      sel_idx = (state == IDLE) ? idx_d       : idx_q;
      sel_err = (state == IDLE) ? bad_d       : err_q;
      sel_wr  = (state == IDLE) ? apb.pwrite  : write_q;

      go_access = ((state == IDLE) && setup && (wait_cfg == '0)) ||
                  ((state == WAIT) && apb.psel && apb.penable &&
                   (cnt == WAITCFG_W'(1)));

      commit = (state == ACCESS) && apb.psel && write_q && !err_q;
   end

   always_ff @(posedge clk or posedge preset) begin
      if (preset) begin
         state     <= IDLE;
         idx_q     <= '0;
         write_q   <= 1'b0;
         err_q     <= 1'b0;
         wdata_q   <= '0;
         cnt       <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         pready_q  <= go_access;
         pslverr_q <= go_access && sel_err;
         prdata_q  <= (go_access && !sel_err && !sel_wr) ? rdata : '0;

         case (state)
            IDLE: begin
               if (setup) begin
                  idx_q   <= idx_d;
                  write_q <= apb.pwrite;
                  wdata_q <= apb.pwdata;
                  err_q   <= bad_d;
                  cnt     <= wait_cfg;
                  state   <= (wait_cfg == '0) ? ACCESS : WAIT;
               end
            end
            WAIT: begin
               if (!apb.psel) begin
                  state <= IDLE;
               end else if (apb.penable) begin
                  if (cnt == WAITCFG_W'(1)) begin
                     state <= ACCESS;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            ACCESS: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign apb.pready  = pready_q;
   assign apb.pslverr = pslverr_q;
   assign apb.prdata  = prdata_q;

   apb_slave_regbank #(
      .NUM_REGS (NUM_REGS),
      .ID_VALUE (ID_VALUE)
   ) u_regbank (
      .clk      (clk),
      .preset   (preset),
      .we       (commit),
      .widx     (idx_q),
      .wdata    (wdata_q),
      .ridx     (sel_idx),
      .rdata    (rdata),
      .wait_cfg (wait_cfg)
   );

endmodule
